// File: rtl/ysyx_23060077_bus_arbiter.sv
// Two-master arbiter sharing one memory bus between fetch (IFU) and load/store (LSU).
// One transaction in flight; request fields are captured at grant, with a bounded response wait.
`timescale 1ns/1ps
module ysyx_23060077_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FAIR           = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam bit LSU_PRIORITY = (FAIR == 0);
  localparam logic [CNT_W-1:0] CNT_SAT =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;       // 1 = LSU owns the bus
  logic                last_grant_reg;  // 1 = LSU was granted last
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;

  logic grant_lsu, grant_ifu, accept, timeout_hit, wait_done;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // Under contention the LSU wins unless fairness says it was served last.
  assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || LSU_PRIORITY || !last_grant_reg);
  assign grant_ifu   = ifu_req_valid && !grant_lsu;
  assign accept      = (state_reg == IDLE) && (ifu_req_valid || lsu_req_valid);
  assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_SAT);
  assign wait_done   = mem_resp_valid || timeout_hit;
  assign resp_rdata  = (mem_resp_valid && !wen_reg) ? mem_resp_rdata : '0;
  assign resp_err    = mem_resp_valid ? mem_resp_err : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg      <= grant_lsu;
        last_grant_reg <= grant_lsu;
        addr_reg       <= grant_lsu ? lsu_req_addr : ifu_req_addr;
        wen_reg        <= grant_lsu && lsu_req_wen;
        wdata_reg      <= grant_lsu ? lsu_req_wdata : '0;
        wstrb_reg      <= grant_lsu ? lsu_req_wstrb : '0;
      end
      // Saturating wait counter; it is parked at the limit rather than wrapping.
      if (state_reg == ISSUE && mem_req_ready) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT && !mem_resp_valid && cnt_reg != CNT_SAT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (mem_req_ready) state_next = WAIT;
      WAIT:    if (wait_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset gates every handshake and response so an abandoned transaction never pulses.
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = addr_reg;
    mem_req_wen    = wen_reg;
    mem_req_wdata  = wdata_reg;
    mem_req_wstrb  = wstrb_reg;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          ifu_req_ready = grant_ifu;
          lsu_req_ready = grant_lsu;
        end
        ISSUE: mem_req_valid = 1'b1;
        WAIT: begin
          if (wait_done && owner_reg) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_rdata = resp_rdata;
            lsu_resp_err   = resp_err;
          end else if (wait_done) begin
            ifu_resp_valid = 1'b1;
            ifu_resp_rdata = resp_rdata;
            ifu_resp_err   = resp_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_bus_arbiter.sv
// Bench for the IFU/LSU bus arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration, latching and timeout rules.
`timescale 1ns/1ps
module tb_ysyx_23060077_bus_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_rdata;

  // second instance: strict LSU priority, timeout disabled, auto-responding bus
  logic        f_ifu_valid, f_ifu_ready, f_ifu_resp_valid, f_ifu_resp_err;
  logic [31:0] f_ifu_resp_rdata;
  logic        f_lsu_valid, f_lsu_ready, f_lsu_resp_valid, f_lsu_resp_err;
  logic [31:0] f_lsu_resp_rdata;
  logic        f_mem_req_valid, f_mem_req_ready, f_mem_req_wen;
  logic [31:0] f_mem_req_addr, f_mem_req_wdata;
  logic [3:0]  f_mem_req_wstrb;
  logic        f_mem_resp_valid;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ysyx_23060077_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  ysyx_23060077_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0), .TIMEOUT_CYCLES(0)) dut_prio (
    .clock(clock), .reset(reset),
    .ifu_req_valid(f_ifu_valid), .ifu_req_ready(f_ifu_ready), .ifu_req_addr(32'h0000_1000),
    .ifu_resp_valid(f_ifu_resp_valid), .ifu_resp_rdata(f_ifu_resp_rdata), .ifu_resp_err(f_ifu_resp_err),
    .lsu_req_valid(f_lsu_valid), .lsu_req_ready(f_lsu_ready), .lsu_req_addr(32'h0000_2000),
    .lsu_req_wen(1'b0), .lsu_req_wdata(32'h0), .lsu_req_wstrb(4'h0),
    .lsu_resp_valid(f_lsu_resp_valid), .lsu_resp_rdata(f_lsu_resp_rdata), .lsu_resp_err(f_lsu_resp_err),
    .mem_req_valid(f_mem_req_valid), .mem_req_ready(f_mem_req_ready), .mem_req_addr(f_mem_req_addr),
    .mem_req_wen(f_mem_req_wen), .mem_req_wdata(f_mem_req_wdata), .mem_req_wstrb(f_mem_req_wstrb),
    .mem_resp_valid(f_mem_resp_valid), .mem_resp_rdata(32'h0), .mem_resp_err(1'b0)
  );

  always @(posedge clock) begin
    if (reset) f_mem_resp_valid <= 1'b0;
    else       f_mem_resp_valid <= f_mem_req_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_err = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1;
    tick();
    settle();
    checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_gating: got %b expected 00000",
                         {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid}); end
    reset = 0; idle_inputs();
    settle();
    checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
                   lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, mem_req_valid, mem_req_addr,
                   mem_req_wen, mem_req_wdata, mem_req_wstrb} !== '0) begin
      errors++; $display("FAIL reset_outputs: got addr=%h wdata=%h valid=%b expected all zero",
                         mem_req_addr, mem_req_wdata, mem_req_valid); end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_ifu_fetch();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    settle();
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_grant: got %b expected 10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    settle();
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
      errors++; $display("FAIL fetch_issue: got v=%b a=%h wen=%b strb=%h expected 1 80000000 0 0",
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    settle();
    checks++; if ({ifu_resp_valid, ifu_resp_rdata, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_resp: got v=%b d=%h e=%b lsu_v=%b expected 1 00000413 0 0",
                         ifu_resp_valid, ifu_resp_rdata, ifu_resp_err, lsu_resp_valid); end
    tick();
    mem_resp_valid = 0;
    settle();
    checks++; if ({ifu_resp_valid, mem_req_valid} !== 2'b00) begin
      errors++; $display("FAIL fetch_done: got %b expected 00", {ifu_resp_valid, mem_req_valid}); end
    $display("txn fetch: addr=80000000 rdata=%h", ifu_resp_rdata);
  endtask

  task automatic test_fairness();
    logic exp_lsu;
    do_reset();
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_1000;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_2000;
    mem_req_ready = 1;
    for (int g = 0; g < 6; g++) begin
      exp_lsu = (g % 2 == 0);
      settle();
      checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
        errors++; $display("FAIL fair_grant%0d: got lsu/ifu=%b expected %b", g,
                           {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu}); end
      tick(); settle();
      checks++; if (mem_req_addr !== (exp_lsu ? 32'h0000_2000 : 32'h0000_1000)) begin
        errors++; $display("FAIL fair_addr%0d: got %h expected %h", g, mem_req_addr,
                           exp_lsu ? 32'h0000_2000 : 32'h0000_1000); end
      tick();
      mem_resp_valid = 1;
      settle();
      checks++; if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu, !exp_lsu}) begin
        errors++; $display("FAIL fair_resp%0d: got %b expected %b", g,
                           {lsu_resp_valid, ifu_resp_valid}, {exp_lsu, !exp_lsu}); end
      tick();
      mem_resp_valid = 0;
      $display("txn fair %0d: owner=%s", g, exp_lsu ? "LSU" : "IFU");
    end
    idle_inputs();
  endtask

  task automatic test_store_stall();
    lsu_req_valid = 1; lsu_req_addr = 32'h0F00_0010; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'h3;
    settle();
    checks++; if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL store_grant: got %b expected 1", lsu_req_ready); end
    tick();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !==
                    {1'b1, 32'h0F00_0010, 1'b1, 32'hDEAD_BEEF, 4'h3}) begin
        errors++; $display("FAIL store_stable%0d: got v=%b a=%h w=%b d=%h s=%h", c, mem_req_valid,
                           mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb); end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    settle();
    checks++; if ({lsu_resp_valid, lsu_resp_rdata, lsu_resp_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL store_resp: got v=%b d=%h e=%b expected 1 00000000 0",
                         lsu_resp_valid, lsu_resp_rdata, lsu_resp_err); end
    tick();
    idle_inputs();
    $display("txn store: addr=0f000010 stalled 5 cycles");
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_rdata = 32'h0000_0BAD;
    for (int w = 0; w < TO; w++) begin
      settle();
      checks++; if (ifu_resp_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_early%0d: got %b expected 0", w, ifu_resp_valid); end
      tick();
    end
    settle();
    checks++; if ({ifu_resp_valid, ifu_resp_err, ifu_resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_resp: got v=%b e=%b d=%h expected 1 1 00000000",
                         ifu_resp_valid, ifu_resp_err, ifu_resp_rdata); end
    tick(); tick();
    mem_resp_valid = 1;
    settle();
    checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
      errors++; $display("FAIL late_beat: got %b expected 00", {ifu_resp_valid, lsu_resp_valid}); end
    tick();
    idle_inputs();
    $display("txn timeout: ifu addr=80000100");
  endtask

  task automatic test_lsu_err();
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0040; lsu_req_wen = 0;
    tick();
    idle_inputs(); mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_err = 1; mem_resp_rdata = 32'h0000_0055;
    settle();
    checks++; if ({lsu_resp_valid, lsu_resp_err, lsu_resp_rdata, ifu_resp_valid} !== {1'b1, 1'b1, 32'h55, 1'b0}) begin
      errors++; $display("FAIL lsu_err: got v=%b e=%b d=%h ifu_v=%b expected 1 1 00000055 0",
                         lsu_resp_valid, lsu_resp_err, lsu_resp_rdata, ifu_resp_valid); end
    tick();
    idle_inputs();
    $display("txn lsu_err: addr=00000040");
  endtask

  task automatic test_reset_mid();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0200;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    tick();
    reset = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h7777_7777;
    settle();
    checks++; if (ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pulse: got %b expected 0", ifu_resp_valid); end
    tick();
    reset = 0;
    settle();
    checks++; if ({ifu_resp_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_mid_idle: got v=%b mv=%b a=%h expected 0 0 00000000",
                         ifu_resp_valid, mem_req_valid, mem_req_addr); end
    mem_resp_valid = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    settle();
    checks++; if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_regrant: got %b expected 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0013;
    settle();
    checks++; if ({ifu_resp_valid, ifu_resp_rdata} !== {1'b1, 32'h13}) begin
      errors++; $display("FAIL reset_mid_fetch: got v=%b d=%h expected 1 00000013",
                         ifu_resp_valid, ifu_resp_rdata); end
    tick();
    idle_inputs();
    $display("txn reset_mid: refetch addr=80000004");
  endtask

  task automatic test_random();
    logic        pend_ifu, pend_lsu, last_lsu, win_lsu, pulse, r_err;
    logic [31:0] pi_addr, pl_addr, pl_wdata, e_addr, e_wdata, r_data, exp_data;
    logic        pl_wen, e_wen, exp_err;
    logic [3:0]  pl_wstrb, e_wstrb;
    int          rd, d;
    do_reset();
    pend_ifu = 0; pend_lsu = 0; last_lsu = 0;
    pi_addr = 0; pl_addr = 0; pl_wdata = 0; pl_wen = 0; pl_wstrb = 0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_ifu && $urandom_range(0, 1) == 1) begin
        pend_ifu = 1; pi_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_lsu && ($urandom_range(0, 1) == 1 || !pend_ifu)) begin
        pend_lsu = 1; pl_addr = $urandom; pl_wen = 1'($urandom_range(0, 1));
        pl_wdata = $urandom; pl_wstrb = 4'($urandom_range(0, 15));
      end
      ifu_req_valid = pend_ifu; ifu_req_addr = pi_addr;
      lsu_req_valid = pend_lsu; lsu_req_addr = pl_addr; lsu_req_wen = pl_wen;
      lsu_req_wdata = pl_wdata; lsu_req_wstrb = pl_wstrb;
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_rdata = $urandom;
      // FAIR=1: a contested grant goes to whoever was not served last (LSU after reset).
      win_lsu = (pend_ifu && pend_lsu) ? !last_lsu : pend_lsu;
      settle();
      checks++; if ({lsu_req_ready, ifu_req_ready, lsu_resp_valid, ifu_resp_valid} !== {win_lsu, !win_lsu, 2'b00}) begin
        errors++; $display("FAIL rnd_grant%0d: got %b expected %b", n,
                           {lsu_req_ready, ifu_req_ready, lsu_resp_valid, ifu_resp_valid}, {win_lsu, !win_lsu, 2'b00}); end
      e_addr  = win_lsu ? pl_addr : pi_addr;
      e_wen   = win_lsu ? pl_wen : 1'b0;
      e_wdata = win_lsu ? pl_wdata : 32'h0;
      e_wstrb = win_lsu ? pl_wstrb : 4'h0;
      last_lsu = win_lsu;
      if (win_lsu) pend_lsu = 0; else pend_ifu = 0;
      tick();
      ifu_req_valid = pend_ifu; lsu_req_valid = pend_lsu;
      rd = $urandom_range(0, 3);
      for (int k = 0; k <= rd; k++) begin
        mem_req_ready = (k == rd);
        mem_resp_valid = 1'($urandom_range(0, 1));
        settle();
        checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !==
                      {1'b1, e_addr, e_wen, e_wdata, e_wstrb}) begin
          errors++; $display("FAIL rnd_issue%0d: got a=%h w=%b d=%h s=%h expected %h %b %h %h", n,
                             mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, e_addr, e_wen, e_wdata, e_wstrb); end
        checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0) begin
          errors++; $display("FAIL rnd_quiet%0d: got %b expected 0000", n,
                             {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}); end
        tick();
      end
      d = $urandom_range(0, 5);
      r_err = 1'($urandom_range(0, 1));
      r_data = $urandom;
      for (int w = 0; w <= TO; w++) begin
        mem_req_ready = 0;
        mem_resp_valid = (d < TO) && (w == d);
        mem_resp_err = r_err; mem_resp_rdata = r_data;
        pulse    = (d < TO) ? (w == d) : (w == TO);
        exp_data = (d < TO && !e_wen) ? r_data : 32'h0;
        exp_err  = (d < TO) ? r_err : 1'b1;
        settle();
        checks++; if ({lsu_resp_valid, ifu_resp_valid} !== {pulse && win_lsu, pulse && !win_lsu}) begin
          errors++; $display("FAIL rnd_pulse%0d_w%0d: got lsu/ifu=%b expected %b", n, w,
                             {lsu_resp_valid, ifu_resp_valid}, {pulse && win_lsu, pulse && !win_lsu}); end
        if (pulse) begin
          checks++;
          if ((win_lsu ? {lsu_resp_rdata, lsu_resp_err} : {ifu_resp_rdata, ifu_resp_err}) !== {exp_data, exp_err}) begin
            errors++; $display("FAIL rnd_data%0d: got d=%h e=%b expected %h %b", n,
                               win_lsu ? lsu_resp_rdata : ifu_resp_rdata,
                               win_lsu ? lsu_resp_err : ifu_resp_err, exp_data, exp_err); end
        end
        tick();
        if (pulse) break;
      end
      mem_resp_valid = 0;
      $display("txn rnd %0d: owner=%s addr=%h wen=%0d ready_delay=%0d resp_delay=%0d",
               n, win_lsu ? "LSU" : "IFU", e_addr, e_wen, rd, d);
    end
    idle_inputs();
  endtask

  task automatic test_fair0();
    int ifu_grants, lsu_grants;
    logic got_ifu;
    do_reset();
    ifu_grants = 0; lsu_grants = 0;
    f_ifu_valid = 1; f_lsu_valid = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (f_ifu_ready) ifu_grants++;
      if (f_lsu_ready) lsu_grants++;
      tick();
    end
    checks++; if (lsu_grants != 4) begin
      errors++; $display("FAIL prio_lsu_grants: got %0d expected 4", lsu_grants); end
    checks++; if (ifu_grants != 0) begin
      errors++; $display("FAIL prio_ifu_grants: got %0d expected 0", ifu_grants); end
    f_lsu_valid = 0;
    got_ifu = 0;
    for (int c = 0; c < 4 && !got_ifu; c++) begin
      settle();
      if (f_ifu_ready) got_ifu = 1;
      tick();
    end
    checks++; if (got_ifu !== 1'b1) begin
      errors++; $display("FAIL prio_ifu_after_drop: got %b expected 1", got_ifu); end
    f_ifu_valid = 0;
    $display("txn prio: lsu_grants=%0d ifu_grants=%0d", lsu_grants, ifu_grants);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    f_ifu_valid = 0; f_lsu_valid = 0; f_mem_req_ready = 1;
    test_reset();
    test_ifu_fetch();
    test_fairness();
    test_store_stall();
    test_timeout();
    test_lsu_err();
    test_reset_mid();
    test_random();
    test_fair0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
